key_entry_unit: RTL

Parametrised keypad front end for the calculator. It synchronises and debounces a one-hot switch bank of NUM_KEYS keys and accumulates digit keys into a DIGITS-wide BCD operand. Each command key is delivered as a valid/ready event to the calculator core, carrying a snapshot of the operand. It replaces the fixed 12-switch decode in the calculator top with a sequential block of configurable key count, operand depth and debounce time.

---
 rtl/key_entry_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/key_entry_unit.sv
// key_entry_unit: debounced one-hot keypad front end building a BCD operand and issuing command events.
// Optional auto-repeat of held digit keys is enabled by defining KEY_ENTRY_REPEAT_EN.
module key_entry_unit #(
    parameter int NUM_KEYS      = 12,
    parameter int DIGITS        = 4,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_KEYS-1:0]   sw,
    input  logic                  clr,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic [3:0]            key_code,
    output logic [4*DIGITS-1:0]   key_operand,
    output logic [3:0]            key_ndigits,
    output logic [4*DIGITS-1:0]   operand,
    output logic [3:0]            digit_count,
    output logic                  overflow
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t                state_q, state_d;
    logic [NUM_KEYS-1:0]   s1_q, s_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            cand_q, cand_d, code;
    logic                  idle, one, fire, ev, xfer, digit;
    logic [W-1:0]          operand_q, operand_d, key_operand_q, key_operand_d;
    logic [3:0]            digit_count_q, digit_count_d, key_code_q, key_code_d;
    logic [3:0]            key_ndigits_q, key_ndigits_d;
    logic                  overflow_q, overflow_d, key_valid_q, key_valid_d;

    assign idle = s_q == '0;
    assign one  = $onehot(s_q);

    always_comb begin
        code = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++)
            if (s_q[i]) code = 4'(NUM_KEYS - 1 - i);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        fire    = 1'b0;
        case (state_q)
            IDLE: if (one) begin
                state_d = PRESS_WAIT;
                cand_d  = code;
                cnt_d   = CW'(1);
            end
            PRESS_WAIT: if (!one) state_d = IDLE;
            else if (code != cand_q) begin
                cand_d = code;
                cnt_d  = CW'(1);
            end else if (cnt_q >= CW'(DEBOUNCE)) begin
                state_d = HELD;
                fire    = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
            HELD: if (idle) begin
                state_d = RELEASE_WAIT;
                cnt_d   = CW'(1);
            end
            RELEASE_WAIT: if (!idle) state_d = HELD;
            else if (cnt_q >= CW'(DEBOUNCE)) state_d = IDLE;
            else cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end

`ifdef KEY_ENTRY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    logic [RW-1:0] rep_q, rep_d;
    logic          first_q, first_d, rep_fire;

    // Timer only advances while held on a digit, so RELEASE_WAIT freezes it.
    always_comb begin
        rep_d    = rep_q;
        first_d  = first_q;
        rep_fire = 1'b0;
        if (fire) begin
            rep_d   = '0;
            first_d = 1'b1;
        end else if (state_q == HELD && !idle && cand_q < 4'd10) begin
            if (rep_q + 1'b1 == (first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD))) begin
                rep_fire = 1'b1;
                rep_d    = '0;
                first_d  = 1'b0;
            end else rep_d = rep_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rep_q   <= '0;
            first_q <= 1'b0;
        end else begin
            rep_q   <= rep_d;
            first_q <= first_d;
        end

    assign ev = fire | rep_fire;
`else
    assign ev = fire;
`endif

    assign xfer  = key_valid_q && key_ready;
    assign digit = cand_q < 4'd10;

    always_comb begin
        operand_d     = operand_q;
        digit_count_d = digit_count_q;
        overflow_d    = overflow_q;
        key_valid_d   = key_valid_q && !xfer;
        key_code_d    = key_code_q;
        key_operand_d = key_operand_q;
        key_ndigits_d = key_ndigits_q;
        if (ev && digit) begin
            if (digit_count_q < 4'(DIGITS)) begin
                operand_d     = (operand_q << 4) | W'(cand_q);
                digit_count_d = digit_count_q + 4'd1;
            end else overflow_d = 1'b1;
        end
        // A command may load in the same edge that retires the previous one.
        if (ev && !digit) begin
            if (!key_valid_q || xfer) begin
                key_valid_d   = 1'b1;
                key_code_d    = cand_q;
                key_operand_d = clr ? '0 : operand_q;
                key_ndigits_d = clr ? 4'd0 : digit_count_q;
                operand_d     = '0;
                digit_count_d = 4'd0;
            end else overflow_d = 1'b1;
        end
        if (clr) begin
            operand_d     = '0;
            digit_count_d = 4'd0;
            overflow_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1_q          <= '0;
            s_q           <= '0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            cand_q        <= 4'd0;
            operand_q     <= '0;
            digit_count_q <= 4'd0;
            overflow_q    <= 1'b0;
            key_valid_q   <= 1'b0;
            key_code_q    <= 4'd0;
            key_operand_q <= '0;
            key_ndigits_q <= 4'd0;
        end else begin
            s1_q          <= sw;
            s_q           <= s1_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            operand_q     <= operand_d;
            digit_count_q <= digit_count_d;
            overflow_q    <= overflow_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_operand_q <= key_operand_d;
            key_ndigits_q <= key_ndigits_d;
        end

    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_operand = key_operand_q;
    assign key_ndigits = key_ndigits_q;
    assign operand     = operand_q;
    assign digit_count = digit_count_q;
    assign overflow    = overflow_q;
endmodule
